// File: rtl/sd_clk_gen.sv
// SD card clock generator: toggles sd_clk on divider ticks, emits edge strobes,
// stops glitch-free at a low phase and runs the INIT_CLKS power-up burst.
// Optional build macro SD_CLK_HOLD_EN adds a clk_hold input that freezes the
// running clock low for downstream backpressure.
module sd_clk_gen #(
  parameter int unsigned INIT_CLKS = 74,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clk_en,
  input  logic init_start,
`ifdef SD_CLK_HOLD_EN
  input  logic clk_hold,
`endif
  output logic sd_clk,
  output logic sd_clk_rise,
  output logic sd_clk_fall,
  output logic clk_running,
  output logic init_busy,
  output logic init_done
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // Reject burst lengths the counter cannot hold without wrapping.
  if (64'(INIT_CLKS) < 64'd1 || 64'(INIT_CLKS) > CNT_MAX) begin : g_param_check
    $error("sd_clk_gen: INIT_CLKS must be in 1..2^CNT_W-1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_INIT,
    S_STOP
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             sd_clk_nx, rise_nx, fall_nx, done_nx;
  logic             toggle, hold;

  assign cnt_inc = cnt + CNT_W'(1);

  // Next-state, burst counter and next output values.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    toggle   = 1'b0;
    done_nx  = 1'b0;
    hold     = 1'b0;
`ifdef SD_CLK_HOLD_EN
    // Only a low phase may be frozen; a high phase always completes.
    hold     = clk_hold && !sd_clk;
`endif
    case (state)
      S_IDLE: begin
        if (init_start) begin
          state_nx = S_INIT;
          cnt_nx   = '0;
        end else if (clk_en) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        toggle = tick && !hold;
        if (init_start) begin
          state_nx = S_INIT;
          cnt_nx   = '0;
        end else if (!clk_en) begin
          // Finish any high phase (current or just starting) before idling.
          state_nx = (sd_clk ^ toggle) ? S_STOP : S_IDLE;
        end
      end
      S_STOP: begin
        toggle = tick;
        if (clk_en) begin
          state_nx = S_RUN;
        end else if (toggle) begin
          state_nx = S_IDLE;
        end
      end
      S_INIT: begin
        toggle = tick;
        if (toggle && sd_clk) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == CNT_W'(INIT_CLKS)) begin
            done_nx  = 1'b1;
            state_nx = clk_en ? S_RUN : S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    sd_clk_nx = sd_clk ^ toggle;
    rise_nx   = toggle && !sd_clk;
    fall_nx   = toggle && sd_clk;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sd_clk      <= 1'b0;
      sd_clk_rise <= 1'b0;
      sd_clk_fall <= 1'b0;
      clk_running <= 1'b0;
      init_busy   <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sd_clk      <= sd_clk_nx;
      sd_clk_rise <= rise_nx;
      sd_clk_fall <= fall_nx;
      clk_running <= (state_nx != S_IDLE);
      init_busy   <= (state_nx == S_INIT);
      init_done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed self-checking bench for sd_clk_gen (default INIT_CLKS=74).
module tb_sd_clk_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic clk_en = 1'b0;
  logic init_start = 1'b0;
`ifdef SD_CLK_HOLD_EN
  logic clk_hold = 1'b0;
`endif
  logic sd_clk, sd_clk_rise, sd_clk_fall, clk_running, init_busy, init_done;

  int n_cmp = 0;
  int n_bad = 0;

  sd_clk_gen dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .clk_en     (clk_en),
    .init_start (init_start),
`ifdef SD_CLK_HOLD_EN
    .clk_hold   (clk_hold),
`endif
    .sd_clk     (sd_clk),
    .sd_clk_rise(sd_clk_rise),
    .sd_clk_fall(sd_clk_fall),
    .clk_running(clk_running),
    .init_busy  (init_busy),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled at that edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rises, falls, dones, done_at, done_fall, done_run;

    // Reset held with ticks running and clk_en high.
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick = i[0];
      cyc();
      check($sformatf("rst_sd_clk[%0d]", i), int'(sd_clk), 0);
      check($sformatf("rst_rise[%0d]", i), int'(sd_clk_rise), 0);
      check($sformatf("rst_fall[%0d]", i), int'(sd_clk_fall), 0);
      check($sformatf("rst_running[%0d]", i), int'(clk_running), 0);
      check($sformatf("rst_done[%0d]", i), int'(init_done), 0);
    end
    clk_en = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick = ~i[0];
      cyc();
      check($sformatf("idle_sd_clk[%0d]", i), int'(sd_clk), 0);
      check($sformatf("idle_running[%0d]", i), int'(clk_running), 0);
    end

    // Run with a tick every 4 cycles, then drop clk_en one cycle after a rise.
    for (int i = 0; i < 48; i++) begin
      int ph;
      bit e_clk, e_rise, e_fall, e_run;
      clk_en = (i <= 27);
      tick   = (i % 4 == 3);
      cyc();
      ph     = (i - 3) / 4;
      e_clk  = (i >= 3 && i <= 31) && (ph % 2 == 0);
      e_rise = (i <= 31) && (i % 8 == 3);
      e_fall = (i <= 31) && (i % 8 == 7);
      e_run  = (i <= 30);
      check($sformatf("run_sd_clk[%0d]", i), int'(sd_clk), int'(e_clk));
      check($sformatf("run_rise[%0d]", i), int'(sd_clk_rise), int'(e_rise));
      check($sformatf("run_fall[%0d]", i), int'(sd_clk_fall), int'(e_fall));
      check($sformatf("run_running[%0d]", i), int'(clk_running), int'(e_run));
    end

    // Init burst with clk_en low, tick every 2 cycles, repeat init_start ignored.
    rises = 0; falls = 0; dones = 0; done_at = -1; done_fall = 0; done_run = 1;
    for (int i = 0; i < 400; i++) begin
      init_start = (i == 0 || i == 100);
      tick       = (i % 2 == 1);
      cyc();
      if (sd_clk_rise) rises++;
      if (sd_clk_fall) falls++;
      if (init_done) begin
        dones++;
        done_at   = i;
        done_fall = int'(sd_clk_fall);
        done_run  = int'(clk_running);
      end
      if (i == 50) check("init_busy_mid", int'(init_busy), 1);
    end
    init_start = 1'b0;
    check("init_rises", rises, 74);
    check("init_falls", falls, 74);
    check("init_dones", dones, 1);
    check("init_done_cycle", done_at, 295);
    check("init_done_with_fall", done_fall, 1);
    check("init_then_idle", done_run, 0);
    check("init_end_sd_clk", int'(sd_clk), 0);

    // Init with clk_en high and back-to-back ticks, continuing into RUN.
    clk_en = 1'b1;
    for (int i = 0; i < 160; i++) begin
      init_start = (i == 0);
      tick       = 1'b1;
      cyc();
      check($sformatf("bb_sd_clk[%0d]", i), int'(sd_clk), int'(i[0]));
      check($sformatf("bb_rise[%0d]", i), int'(sd_clk_rise), int'(i[0]));
      check($sformatf("bb_fall[%0d]", i), int'(sd_clk_fall), int'(i >= 2 && !i[0]));
      check($sformatf("bb_done[%0d]", i), int'(init_done), int'(i == 148));
      check($sformatf("bb_busy[%0d]", i), int'(init_busy), int'(i < 148));
      check($sformatf("bb_running[%0d]", i), int'(clk_running), 1);
    end
    init_start = 1'b0;
    clk_en     = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("bb_stop_sd_clk", int'(sd_clk), 0);
    check("bb_stop_running", int'(clk_running), 0);

    // Reset after 10 cycles of a burst, then a fresh full burst.
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      init_start = (i == 0);
      tick       = 1'b1;
      cyc();
      if (init_done) dones++;
    end
    init_start = 1'b0;
    check("abort_pre_sd_clk", int'(sd_clk), 1);
    reset = 1'b0;
    #1;
    check("abort_sd_clk_async", int'(sd_clk), 0);
    check("abort_running", int'(clk_running), 0);
    check("abort_busy", int'(init_busy), 0);
    cyc();
    check("abort_no_done", dones + int'(init_done), 0);
    reset = 1'b1;
    rises = 0; falls = 0; dones = 0; done_at = -1;
    for (int i = 0; i < 200; i++) begin
      init_start = (i == 0);
      tick       = 1'b1;
      cyc();
      if (sd_clk_rise) rises++;
      if (sd_clk_fall) falls++;
      if (init_done) begin
        dones++;
        done_at = i;
      end
    end
    init_start = 1'b0;
    check("reinit_rises", rises, 74);
    check("reinit_falls", falls, 74);
    check("reinit_dones", dones, 1);
    check("reinit_done_cycle", done_at, 148);
    check("reinit_running", int'(clk_running), 0);

`ifdef SD_CLK_HOLD_EN
    // Hold while high: one fall, frozen low over 5 ticks, rise after release.
    clk_en = 1'b1;
    tick   = 1'b0;
    cyc();
    tick = 1'b1;
    cyc();
    check("hold_pre_rise", int'(sd_clk_rise), 1);
    clk_hold = 1'b1;
    cyc();
    check("hold_fall_sd_clk", int'(sd_clk), 0);
    check("hold_fall", int'(sd_clk_fall), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("hold_sd_clk[%0d]", i), int'(sd_clk), 0);
      check($sformatf("hold_rise[%0d]", i), int'(sd_clk_rise), 0);
      check($sformatf("hold_running[%0d]", i), int'(clk_running), 1);
    end
    clk_hold = 1'b0;
    cyc();
    check("hold_release_sd_clk", int'(sd_clk), 1);
    check("hold_release_rise", int'(sd_clk_rise), 1);
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("hold_stop_sd_clk", int'(sd_clk), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_clk_gen.md
Name: sd_clk_gen

Overview:
- Generates the SD card clock (sd_clk) from the one-cycle tick pulse produced by the upstream divider counter; each tick is one half-period of sd_clk.
- Provides rise/fall edge strobes in the system clock domain for the downstream command/data shifters.
- Supports a start/stop request with glitch-free stopping at a low phase, and the power-up initialisation burst of INIT_CLKS clocks.

Parameters:
- INIT_CLKS, 74, number of full sd_clk cycles issued by an init burst (1..2^CNT_W-1).
- CNT_W, 8, width of the init-burst cycle counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle half-period strobe from the divider; may be high on consecutive cycles.
- clk_en  in  1  level; request continuous sd_clk.
- init_start  in  1  one-cycle pulse; start init burst.
- sd_clk  out  1  SD card clock, registered.
- sd_clk_rise  out  1  one-cycle strobe, high in the cycle sd_clk first reads 1.
- sd_clk_fall  out  1  one-cycle strobe, high in the cycle sd_clk first reads 0.
- clk_running  out  1  high while in RUN, INIT or STOPPING.
- init_busy  out  1  high while in INIT.
- init_done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Clock and reset: reset is asynchronous and active-low; all state is updated on posedge clk.
- Reset values: sd_clk=0, sd_clk_rise=0, sd_clk_fall=0, clk_running=0, init_busy=0, init_done=0, state=IDLE, cycle counter=0.
- Toggle rule: in RUN, INIT or STOPPING, a cycle with tick=1 inverts sd_clk.
  - The new value appears the following cycle.
  - The matching strobe (rise for 0->1, fall for 1->0) is asserted in that same following cycle for exactly one cycle.
- No toggle without tick. sd_clk holds its value and both strobes are 0.
- IDLE: sd_clk=0; tick is ignored.
  - init_start=1 -> INIT, counter cleared.
  - Otherwise clk_en=1 -> RUN.
  - init_start has priority when both are asserted.
- RUN: toggles on every tick.
  - init_start=1 -> INIT. Counter cleared; the current phase continues without a glitch.
  - clk_en=0 with sd_clk=0, and no toggle that cycle -> IDLE.
  - clk_en=0 with sd_clk=1, or with a rising toggle in progress -> STOPPING.
- STOPPING: waits for the next tick, drives sd_clk 1->0 (sd_clk_fall strobes), then -> IDLE.
  - clk_en reasserted while in STOPPING -> RUN; no phase change.
- INIT: toggles on every tick and increments the counter on each falling toggle. clk_en and further init_start pulses are ignored.
- Burst completion: the falling toggle that brings the count to INIT_CLKS ends the burst.
  - init_done pulses in the same cycle as that sd_clk_fall.
  - Next state: RUN if clk_en=1, else IDLE.
- Stop guarantee: sd_clk is never stopped high. Every high phase is at least one full tick interval; no runt pulses.
- Reset mid-operation: sd_clk goes to 0 immediately, asynchronously. Any partial burst is abandoned, and no init_done is issued.
- Counter width: the counter never wraps, because INIT_CLKS < 2^CNT_W. Parameter values outside 1..2^CNT_W-1 are illegal (elaboration-time check).

Optional Feature:
- Macro: SD_CLK_HOLD_EN.
- With the macro defined:
  - An extra input clk_hold (1 bit) is added after init_start.
  - In RUN, while clk_hold=1, ticks are ignored once sd_clk=0, freezing the clock low for downstream backpressure (e.g. FIFO full).
  - A pending rising toggle is suppressed. If sd_clk=1, the next tick still drives it low.
  - clk_running stays 1 while frozen. Toggling resumes on the first tick after clk_hold=0.
  - clk_hold has no effect in INIT or STOPPING.
- Without the macro: the port is absent and behaviour is as above.

Test Plan:
- Reset: assert reset low with tick free-running -> sd_clk=0, all strobes 0, clk_running=0. Release, clk_en=0 -> stays in IDLE, sd_clk=0.
- Run: clk_en=1, tick every 4 cycles -> sd_clk period 8 cycles; sd_clk_rise and sd_clk_fall alternate, each 1 cycle wide, coincident with the sd_clk edges.
- Stop while high: drop clk_en 1 cycle after sd_clk rises -> exactly one further tick drives sd_clk low with sd_clk_fall, then IDLE; clk_running=0; no further edges.
- Init burst: INIT_CLKS=74, init_start pulse, clk_en=0 -> exactly 74 rising and 74 falling strobes. init_done pulses with the 74th fall, then IDLE. A second init_start mid-burst is ignored.
- Init with clk_en=1 and back-to-back ticks -> sd_clk toggles every cycle; after init_done it continues in RUN with no missing or double edge.
- Reset mid-burst after 10 cycles -> sd_clk=0 immediately, no init_done. A fresh init_start then yields a full 74 cycles.
- SD_CLK_HOLD_EN build: assert clk_hold while sd_clk=1 -> one fall, then frozen low across 5 ticks. Deassert -> rise on the next tick.
